// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and the {pc, instr} fetch entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry {pc, instr} FIFO with flush; ports clk, rst, push_i/push_data_i, pop_i, flush_i, count_o, head_o
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o
);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_pop;
  assign do_pop = pop_i && cnt_q != '0;
  always_comb begin
    wr_d = flush_i ? '0 : wr_q + AW'(push_i);
    rd_d = flush_i ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush_i ? '0 : cnt_q + CW'(push_i) - CW'(do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
  end
  assign count_o = cnt_q;
  assign head_o = cnt_q != '0 ? mem_q[rd_q] : '0;
endmodule

// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer: sequential instruction prefetch with credit-limited requests, redirect flush and in-flight discard; ports: reset/redirect/redirect_pc in, imem_req/imem_addr out, imem_gnt/imem_rvalid/imem_rdata in, instr_valid/instr/instr_pc out, instr_ready in
module fetch_prefetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, count;
  logic gnt, rsp, drop, push, pop;
  fetch_entry_t head;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push_i(push),
    .push_data_i('{pc: resp_pc_q, instr: imem_rdata}),
    .pop_i(pop),
    .flush_i(redirect),
    .count_o(count),
    .head_o(head)
  );
  // Outstanding requests reserve FIFO slots, so a response can never hit a full FIFO
  assign imem_req = !reset && !redirect && ({1'b0, count} + {1'b0, out_q} < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign gnt = imem_req && imem_gnt;
  assign rsp = imem_rvalid && out_q != '0;
  assign drop = rsp && disc_q != '0;
  assign push = rsp && !drop && !redirect;
  assign pop = instr_valid && instr_ready && !redirect;
  assign instr_valid = count != '0;
  assign instr = head.instr;
  assign instr_pc = head.pc;
  // On redirect every request still in flight is stale, including ones already marked for discard
  always_comb begin
    fetch_pc_d = redirect ? redirect_pc : fetch_pc_q + (gnt ? XLEN'(4) : '0);
    resp_pc_d = redirect ? redirect_pc : resp_pc_q + (push ? XLEN'(4) : '0);
    out_d = out_q + CW'(gnt) - CW'(rsp);
    disc_d = redirect ? out_q - CW'(rsp) : disc_q - CW'(drop);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q <= '0;
      disc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q <= resp_pc_d;
      out_q <= out_d;
      disc_q <= disc_d;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb_fetch_prefetch_buffer: scoreboard bench with an in-order memory model and redirect epochs
module tb_fetch_prefetch_buffer;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1, redirect = 0, imem_gnt = 0, imem_rvalid = 0, instr_ready = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0;
  logic imem_req, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc;
  fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; logic [31:0] data; int due; int ep;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} exp_t;
  req_t pend[$];
  exp_t expq[$];
  req_t r;
  exp_t e;
  int total = 0, bad = 0;
  int cyc = 0, anchor = 0, epoch = 0, grants = 0, pops = 0, stale = 0, drop_exp = 0, redir_cyc = 0, first_cyc = 0;
  bit seen_first = 0, prev_rst = 1;
  logic [31:0] first_pc = 0, model_pc = 0, key = 0;
  int gnt_pct = 100, ready_pct = 100, lat_min = 1, lat_max = 1, redir_pct = 0;
  bit redir_cmd = 0;
  logic [31:0] redir_tgt = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  function automatic bit roll(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction
  // memory and stimulus driver; responses tagged with the epoch they were issued in
  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset) begin
      pend.delete();
      expq.delete();
      model_pc = 32'h0;
      epoch++;
      stale = 0;
      drop_exp = 0;
      imem_gnt = 0;
      imem_rvalid = 0;
      redirect = 0;
      instr_ready = 0;
      prev_rst = 1;
    end else begin
      imem_gnt = roll(gnt_pct);
      instr_ready = roll(ready_pct);
      redirect = redir_cmd || roll(redir_pct);
      redirect_pc = redir_cmd ? redir_tgt : (roll(20) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC));
      redir_cmd = 0;
      imem_rvalid = pend.size() != 0 && pend[0].due <= cyc;
      imem_rdata = imem_rvalid ? pend[0].data : $urandom;
      #1;
      if (prev_rst) begin
        anchor = cyc;
        seen_first = 0;
        prev_rst = 0;
      end
      chk("imem_req", imem_req, !redirect && (expq.size() + pend.size() < DEPTH));
      if (imem_req) chk("imem_addr", imem_addr, model_pc);
      if (imem_req && imem_gnt) begin
        pend.push_back('{model_pc, model_pc ^ key, cyc + int'($urandom_range(lat_max, lat_min)), epoch});
        model_pc += 4;
        grants++;
      end
      #2;
      if (redirect) begin
        drop_exp = pend.size();
        stale = 0;
        epoch++;
        expq.delete();
        model_pc = redirect_pc;
        redir_cyc = cyc;
        seen_first = 0;
      end
      if (imem_rvalid) begin
        r = pend.pop_front();
        if (r.ep != epoch) stale++;
        else expq.push_back('{r.addr, r.data});
      end
    end
  end
  // monitor: compares the FIFO head against the scoreboard on every handshake
  initial forever begin
    @(negedge clk);
    #2;
    if (!reset) begin
      chk("instr_valid", instr_valid, expq.size() != 0);
      if (instr_valid && !seen_first) begin
        seen_first = 1;
        first_cyc = cyc;
        first_pc = instr_pc;
      end
      if (instr_valid && instr_ready && !redirect && expq.size() != 0) begin
        e = expq.pop_front();
        chk("instr_pc", instr_pc, e.pc);
        chk("instr", instr, e.ins);
        pops++;
      end
    end
  end
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic do_release();
    @(posedge clk);
    #2 reset = 0;
    grants = 0;
    pops = 0;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1;
    do_release();
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_pc"}, instr_pc, 32'h0);
  endtask
  task automatic redir(input logic [31:0] tgt);
    redir_tgt = tgt;
    redir_cmd = 1;
  endtask
  initial begin
    cycles(3);
    #2;
    chk_reset_outputs("rst");
    do_release();
    cycles(20);
    chk("t1_first_lat", first_cyc - anchor, 2);
    chk("t1_first_pc", first_pc, 32'h0);
    chk("t1_pops", pops, 18);
    ready_pct = 0;
    do_reset();
    cycles(10);
    #2;
    chk("t2_grants", grants, 4);
    chk("t2_req_low", imem_req, 0);
    chk("t2_no_pops", pops, 0);
    chk("t2_head_pc", first_pc, 32'h0);
    ready_pct = 100;
    pops = 0;
    cycles(4);
    chk("t2_drain", pops, 4);
    cycles(6);
    lat_min = 3;
    lat_max = 3;
    key = 32'h5A5A_0000;
    do_reset();
    cycles(8);
    redir(32'h100);
    cycles(20);
    chk("t3_inflight", drop_exp, 3);
    chk("t3_dropped", stale, 3);
    chk("t3_first_pc", first_pc, 32'h100);
    chk("t3_first_lat", first_cyc - redir_cyc, 5);
    lat_min = 1;
    lat_max = 1;
    do_reset();
    cycles(6);
    redir(32'h100);
    cycles(10);
    chk("t4_dropped", stale, 1);
    chk("t4_first_pc", first_pc, 32'h100);
    chk("t4_first_lat", first_cyc - redir_cyc, 3);
    cycles(5);
    redir(32'h200);
    cycles(1);
    redir(32'h300);
    cycles(10);
    chk("t5_first_pc", first_pc, 32'h300);
    chk("t5_first_lat", first_cyc - redir_cyc, 3);
    chk("t5_dropped", stale, drop_exp);
    lat_min = 3;
    lat_max = 3;
    ready_pct = 0;
    do_reset();
    cycles(4);
    #2 reset = 1;
    #1 chk_reset_outputs("midrst");
    ready_pct = 100;
    do_release();
    cycles(10);
    chk("t6_first_pc", first_pc, 32'h0);
    chk("t6_first_lat", first_cyc - anchor, 4);
    key = $urandom;
    gnt_pct = 70;
    ready_pct = 70;
    lat_min = 1;
    lat_max = 4;
    redir_pct = 3;
    pops = 0;
    cycles(3000);
    redir_pct = 0;
    gnt_pct = 100;
    ready_pct = 100;
    cycles(30);
    chk("t7_progress", pops > 500, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
